// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes and fetch state encoding
package cpu_pkg;

  localparam int INST_WIDTH = 16;
  localparam int PC_WIDTH   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter register, load has priority over increment
module pc_counter #(
  parameter int                  PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  input  logic                incr,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (incr) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch stage feeding the decoder
// Optional HALT opcode detection enabled by defining HALT_DETECT_EN.
module inst_fetch #(
  parameter int                  PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  INST_WIDTH = cpu_pkg::INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_rd_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  imem_valid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  halted
);

  import cpu_pkg::*;

  fetch_state_e          state_q, state_d;
  logic                  drop_q, drop_d;
  logic [INST_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic                  valid_q, valid_d;
  logic                  pc_load, pc_incr;
  logic [PC_WIDTH-1:0]   pc;
  logic                  is_halt_op;

  pc_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (branch_target),
    .incr       (pc_incr),
    .pc         (pc)
  );

`ifdef HALT_DETECT_EN
  assign is_halt_op = (instr_q[INST_WIDTH-1 -: 4] == OP_HALT);
  assign halted     = (state_q == HALT);
`else
  assign is_halt_op = 1'b0;
  assign halted     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    pc_load  = 1'b0;
    pc_incr  = 1'b0;
    case (state_q)
      FETCH: begin
        state_d = WAIT;
        // The request leaving this cycle still targets the old pc; its reply must be thrown away.
        if (branch_taken) begin
          pc_load = 1'b1;
          drop_d  = 1'b1;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          if (imem_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            instr_d  = imem_data;
            pc_out_d = pc;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          if (is_halt_op) begin
            state_d = HALT;
          end else begin
            pc_incr = 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      drop_q   <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_rd_en  = (state_q == FETCH) && !rst;
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam int PW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst, stall, branch_taken;
  logic [PW-1:0] branch_target;
  logic          imem_rd_en, imem_valid, inst_valid, halted;
  logic [PW-1:0] imem_addr, pc_out;
  logic [IW-1:0] imem_data, instruction;

  logic          w_rd_en, w_inst_valid, w_halted;
  logic [PW-1:0] w_addr, w_pc_out;
  logic [IW-1:0] w_instruction;

  int            vectors = 0;
  int            errors  = 0;
  logic [IW-1:0] mem [256];
  int            lat = 1;
  bit            rand_lat = 1'b0;
  bit            mon_en = 1'b0;
  bit            resp_pend = 1'b0;
  int            resp_cnt = 0;
  logic [PW-1:0] resp_addr = '0;
  logic [PW-1:0] exp_pc = '0;
  int            idle = 0;
  bit            ok;

  always #5 clk = ~clk;

  inst_fetch u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .instruction   (instruction),
    .inst_valid    (inst_valid),
    .pc_out        (pc_out),
    .halted        (halted)
  );

  inst_fetch #(.RESET_PC(8'hFF)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rd_en    (w_rd_en),
    .imem_addr     (w_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .instruction   (w_instruction),
    .inst_valid    (w_inst_valid),
    .pc_out        (w_pc_out),
    .halted        (w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_rd(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (imem_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Memory: one outstanding read, answered after a fixed or random latency.
  initial begin
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_pend = 1'b0;
      end else if (imem_rd_en) begin
        resp_pend = 1'b1;
        resp_addr = imem_addr;
        resp_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      if (resp_pend) begin
        if (resp_cnt <= 1) begin
          imem_valid = 1'b1;
          imem_data  = mem[resp_addr];
          resp_pend  = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // Reference: the next presented word is at target after a redirect, else one past the consumed word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_pc = 8'h00;
        idle   = 0;
      end else begin
        chk("rd_during_valid", 32'(imem_rd_en & inst_valid), 32'd0);
`ifndef HALT_DETECT_EN
        chk("halted_tied_low", 32'(halted), 32'd0);
`endif
        if (inst_valid) begin
          chk("model_pc_out", 32'(pc_out), 32'(exp_pc));
          chk("model_instruction", 32'(instruction), 32'(mem[exp_pc]));
          idle = 0;
        end else begin
          idle++;
          if (idle > 150) begin
            chk("liveness_idle_cycles", 32'(idle), 32'd0);
            idle = 0;
          end
        end
        if (branch_taken) begin
          exp_pc = branch_target;
        end else if (inst_valid && !stall) begin
          exp_pc = exp_pc + 8'd1;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    mem[0] = 16'h0123;
    rst = 1'b1; stall = 1'b1; branch_taken = 1'b0; branch_target = '0;
    lat = 1; rand_lat = 1'b0; mon_en = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_pc_out", 32'(pc_out), 32'h00);
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wrap_addr", 32'(w_addr), 32'hFF);
    @(posedge clk); #1 rst = 1'b0;

    wait_rd(20, ok);
    chk("req0_seen", 32'(ok), 32'd1);
    chk("req0_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    chk("lat_n1_valid", 32'(inst_valid), 32'd0);
    chk("lat_n1_rd_en", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(inst_valid), 32'd1);
    chk("lat_n2_instruction", 32'(instruction), 32'h0123);
    chk("lat_n2_pc_out", 32'(pc_out), 32'h00);
    chk("wrap_pc_out", 32'(w_pc_out), 32'hFF);

    repeat (5) begin
      @(negedge clk);
      chk("stall_instruction", 32'(instruction), 32'h0123);
      chk("stall_pc_out", 32'(pc_out), 32'h00);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
    end
    lat = 3;
    @(posedge clk); #1 stall = 1'b0;
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    chk("req1_rd_en", 32'(imem_rd_en), 32'd1);
    chk("req1_addr", 32'(imem_addr), 32'h01);
    chk("wrap_rd_en", 32'(w_rd_en), 32'd1);
    chk("wrap_next_addr", 32'(w_addr), 32'h00);

    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 8'h40;
    @(posedge clk); #1 branch_taken = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (imem_rd_en) ok = 1'b1;
      else chk("drop_no_valid", 32'(inst_valid), 32'd0);
    end
    chk("redir_req_seen", 32'(ok), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    wait_valid(20, ok);
    chk("redir_valid_seen", 32'(ok), 32'd1);
    chk("redir_pc_out", 32'(pc_out), 32'h40);
    chk("redir_instruction", 32'(instruction), 32'(mem[8'h40]));

    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 8'h10;
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("hold_br_valid", 32'(inst_valid), 32'd0);
    chk("hold_br_rd_en", 32'(imem_rd_en), 32'd1);
    chk("hold_br_addr", 32'(imem_addr), 32'h10);

    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 399) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = 8'($urandom);
    end
    @(posedge clk); #1 rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;

`ifdef HALT_DETECT_EN
    mon_en = 1'b0; rand_lat = 1'b0; lat = 1; mem[5] = 16'hF000;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; branch_taken = 1'b1; branch_target = 8'h05;
    @(posedge clk); #1 branch_taken = 1'b0;
    wait_valid(20, ok);
    chk("halt_word_seen", 32'(ok), 32'd1);
    chk("halt_word_pc", 32'(pc_out), 32'h05);
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 8'h33;
    @(posedge clk); #1 branch_taken = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("halt_no_rd", 32'(imem_rd_en), 32'd0);
      chk("halt_stays", 32'(halted), 32'd1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_rd_en", 32'(imem_rd_en), 32'd1);
    chk("halt_rst_addr", 32'(imem_addr), 32'h00);
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
